// File: rtl/hazard_pipe_ctrl.sv
// rtl/hazard_pipe_ctrl.sv - pipeline stage tracking, load-use/branch/freeze control and event counters
module hazard_pipe_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regWrite,
    input  logic                  id_memRead,
    input  logic                  ex_branch_taken,
    input  logic                  mem_stall,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  if_id_flush,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_mem_regRd,
    output logic                  ex_mem_regWrite,
    output logic [REG_ADDR_W-1:0] mem_wb_regRd,
    output logic                  mem_wb_regWrite,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    stage_t                ex_q, mem_q, wb_q, id_entry;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q;
    logic                  branch, hazard;

    // A write to x0 never counts as a write, so it is dropped at every hop.
    function automatic stage_t advance(input stage_t s);
        stage_t r;
        r           = s;
        r.reg_write = s.reg_write & s.valid & (s.rd != '0);
        return r;
    endfunction

    always_comb begin
        id_entry.valid     = id_valid;
        id_entry.rd        = id_valid ? id_rd : '0;
        id_entry.reg_write = id_regWrite & id_valid & (id_rd != '0);
        id_entry.mem_read  = id_memRead & id_valid;
    end

    assign branch = ex_q.valid & ex_branch_taken;
    assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ex_q.rd)) | (id_uses_rs2 & (id_rs2 == ex_q.rd)));

    // Freeze beats branch, branch beats load-use.
    always_comb begin
        pc_we          = 1'b1;
        if_id_we       = 1'b1;
        if_id_flush    = 1'b0;
        load_use_stall = 1'b0;
        if (mem_stall) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
        end else if (branch) begin
            if_id_flush = 1'b1;
        end else if (hazard) begin
            load_use_stall = 1'b1;
            pc_we          = 1'b0;
            if_id_we       = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!mem_stall) begin
                wb_q  <= advance(mem_q);
                mem_q <= advance(ex_q);
                if (branch || hazard) begin
                    ex_q     <= '0;
                    ex_rs1_q <= '0;
                    ex_rs2_q <= '0;
                end else begin
                    ex_q     <= id_entry;
                    ex_rs1_q <= id_valid ? id_rs1 : '0;
                    ex_rs2_q <= id_valid ? id_rs2 : '0;
                end
                if (branch && (flush_cnt != {CNT_W{1'b1}}))
                    flush_cnt <= flush_cnt + 1'b1;
            end
            if (!pc_we && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ex_rs1          = ex_q.valid ? ex_rs1_q : '0;
    assign ex_rs2          = ex_q.valid ? ex_rs2_q : '0;
    assign ex_mem_regRd    = mem_q.valid ? mem_q.rd : '0;
    assign ex_mem_regWrite = mem_q.valid & mem_q.reg_write;
    assign mem_wb_regRd    = wb_q.valid ? wb_q.rd : '0;
    assign mem_wb_regWrite = wb_q.valid & wb_q.reg_write;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb/tb_hazard_pipe_ctrl.sv - table-driven, scoreboarded check of hazard_pipe_ctrl
module tb_hazard_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_regWrite, id_memRead;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, mem_stall;
    logic       pc_we, if_id_we, if_id_flush, load_use_stall;
    logic [4:0] ex_rs1, ex_rs2, ex_mem_regRd, mem_wb_regRd;
    logic       ex_mem_regWrite, mem_wb_regWrite;
    logic [3:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_pipe_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_mem_regRd(ex_mem_regRd), .ex_mem_regWrite(ex_mem_regWrite),
        .mem_wb_regRd(mem_wb_regRd), .mem_wb_regWrite(mem_wb_regWrite),
        .load_use_stall(load_use_stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic       rst, v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mr, br, ms;
        logic       chk, pc, ifid, fl, lus;
        logic [4:0] xr1, xr2, emrd;
        logic       emrw;
        logic [4:0] mwrd;
        logic       mwrw;
        logic [3:0] sc, fc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t cur;
    int   total = 0;
    int   bad   = 0;

    task automatic in_(input logic r, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic br, input logic ms);
        cur.rst = r; cur.v = v; cur.rs1 = rs1; cur.rs2 = rs2; cur.u1 = u1; cur.u2 = u2;
        cur.rd = rd; cur.rw = rw; cur.mr = mr; cur.br = br; cur.ms = ms;
    endtask

    task automatic ex_(input logic chk, input logic pc, input logic ifid, input logic fl, input logic lus,
                       input logic [4:0] xr1, input logic [4:0] xr2, input logic [4:0] emrd, input logic emrw,
                       input logic [4:0] mwrd, input logic mwrw, input logic [3:0] sc, input logic [3:0] fc);
        cur.chk = chk; cur.pc = pc; cur.ifid = ifid; cur.fl = fl; cur.lus = lus;
        cur.xr1 = xr1; cur.xr2 = xr2; cur.emrd = emrd; cur.emrw = emrw;
        cur.mwrd = mwrd; cur.mwrw = mwrw; cur.sc = sc; cur.fc = fc;
        tbl.push_back(cur);
    endtask

    task automatic cmp(input int step, input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL step%0d %s: got %0d expected %0d", step, nm, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_regWrite = 0; id_memRead = 0; ex_branch_taken = 0; mem_stall = 0;

        //  rst v rs1 rs2 u1 u2 rd rw mr br ms        chk pc ifid fl lus xr1 xr2 emrd emrw mwrd mwrw sc fc
        in_(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      ex_(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // straight-line: add x5, then unrelated instructions
        in_(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_(0, 1, 3, 4, 1, 1, 6, 1, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        in_(0, 1, 8, 9, 1, 1, 10, 0, 0, 0, 0);     ex_(1, 1, 1, 0, 0, 3, 4, 5, 1, 0, 0, 0, 0);
        in_(0, 1, 1, 0, 1, 0, 7, 1, 1, 0, 0);      ex_(1, 1, 1, 0, 0, 8, 9, 6, 1, 5, 1, 0, 0);
        // load-use on rs2 = 7, held for one cycle
        in_(0, 1, 3, 7, 1, 1, 9, 1, 0, 0, 0);      ex_(1, 0, 0, 0, 1, 1, 0, 10, 0, 6, 1, 0, 0);
        in_(0, 1, 3, 7, 1, 1, 9, 1, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 0, 0, 7, 1, 10, 0, 1, 0);
        // load to x0, then a reader of x0: no stall
        in_(0, 1, 2, 0, 1, 0, 0, 1, 1, 0, 0);      ex_(1, 1, 1, 0, 0, 3, 7, 0, 0, 7, 1, 1, 0);
        in_(0, 1, 0, 0, 1, 1, 4, 1, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 2, 0, 9, 1, 0, 0, 1, 0);
        // lw x7 then rs1=7 with uses_rs1=0: no stall
        in_(0, 1, 5, 0, 1, 0, 7, 1, 1, 0, 0);      ex_(1, 1, 1, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0);
        in_(0, 1, 7, 3, 0, 1, 2, 1, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 5, 0, 4, 1, 0, 0, 1, 0);
        // branch over a load-use match
        in_(0, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0);      ex_(1, 1, 1, 0, 0, 7, 3, 7, 1, 4, 1, 1, 0);
        in_(0, 1, 8, 0, 1, 0, 3, 1, 0, 1, 0);      ex_(1, 1, 1, 1, 0, 1, 0, 2, 1, 7, 1, 1, 0);
        in_(0, 1, 1, 2, 1, 1, 11, 1, 0, 0, 0);     ex_(1, 1, 1, 0, 0, 0, 0, 8, 1, 2, 1, 1, 1);
        // mem_stall 3 cycles over a load-use condition
        in_(0, 1, 2, 0, 1, 0, 7, 1, 1, 0, 0);      ex_(1, 1, 1, 0, 0, 1, 2, 0, 0, 8, 1, 1, 1);
        in_(0, 1, 7, 1, 1, 1, 12, 1, 0, 0, 1);     ex_(1, 0, 0, 0, 0, 2, 0, 11, 1, 0, 0, 1, 1);
        in_(0, 1, 7, 1, 1, 1, 12, 1, 0, 0, 1);     ex_(1, 0, 0, 0, 0, 2, 0, 11, 1, 0, 0, 2, 1);
        in_(0, 1, 7, 1, 1, 1, 12, 1, 0, 0, 1);     ex_(1, 0, 0, 0, 0, 2, 0, 11, 1, 0, 0, 3, 1);
        in_(0, 1, 7, 1, 1, 1, 12, 1, 0, 0, 0);     ex_(1, 0, 0, 0, 1, 2, 0, 11, 1, 0, 0, 4, 1);
        in_(0, 1, 7, 1, 1, 1, 12, 1, 0, 0, 0);     ex_(1, 1, 1, 0, 0, 0, 0, 7, 1, 11, 1, 5, 1);
        // branch while frozen is not flushed or counted until release
        in_(0, 1, 3, 4, 1, 1, 13, 1, 0, 1, 1);     ex_(1, 0, 0, 0, 0, 7, 1, 0, 0, 7, 1, 5, 1);
        in_(0, 1, 3, 4, 1, 1, 13, 1, 0, 1, 0);     ex_(1, 1, 1, 1, 0, 7, 1, 0, 0, 7, 1, 6, 1);
        // invalid ID must enter EX with zeroed sources
        in_(0, 0, 5, 6, 1, 1, 13, 1, 1, 0, 0);     ex_(1, 1, 1, 0, 0, 0, 0, 12, 1, 0, 0, 6, 2);
        // mid-operation reset
        in_(1, 1, 3, 4, 1, 1, 14, 1, 0, 0, 0);     ex_(1, 1, 1, 0, 0, 0, 0, 0, 0, 12, 1, 6, 2);
        in_(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // stall counter saturation at 15
        for (int k = 0; k < 16; k++) begin
            in_(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ex_(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(k), 0);
        end
        in_(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      ex_(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 15, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            cur = tbl[i];
            rst = cur.rst;
            if (cur.rst && cur.chk == 1'b0 || cur.rst && i < 2) begin
                id_valid = 1'($urandom_range(0, 1)); id_rs1 = 5'($urandom_range(0, 31));
                id_rs2 = 5'($urandom_range(0, 31)); id_rd = 5'($urandom_range(0, 31));
                id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
                id_regWrite = 1'($urandom_range(0, 1)); id_memRead = 1'($urandom_range(0, 1));
            end else begin
                id_valid = cur.v; id_rs1 = cur.rs1; id_rs2 = cur.rs2; id_rd = cur.rd;
                id_uses_rs1 = cur.u1; id_uses_rs2 = cur.u2; id_regWrite = cur.rw; id_memRead = cur.mr;
            end
            ex_branch_taken = cur.br;
            mem_stall       = cur.ms;
            sb.push_back(cur);
            @(negedge clk);
            e = sb.pop_front();
            if (e.chk) begin
                cmp(i, "pc_we", int'(pc_we), int'(e.pc));
                cmp(i, "if_id_we", int'(if_id_we), int'(e.ifid));
                cmp(i, "if_id_flush", int'(if_id_flush), int'(e.fl));
                cmp(i, "load_use_stall", int'(load_use_stall), int'(e.lus));
                cmp(i, "ex_rs1", int'(ex_rs1), int'(e.xr1));
                cmp(i, "ex_rs2", int'(ex_rs2), int'(e.xr2));
                cmp(i, "ex_mem_regRd", int'(ex_mem_regRd), int'(e.emrd));
                cmp(i, "ex_mem_regWrite", int'(ex_mem_regWrite), int'(e.emrw));
                cmp(i, "mem_wb_regRd", int'(mem_wb_regRd), int'(e.mwrd));
                cmp(i, "mem_wb_regWrite", int'(mem_wb_regWrite), int'(e.mwrw));
                cmp(i, "stall_cnt", int'(stall_cnt), int'(e.sc));
                cmp(i, "flush_cnt", int'(flush_cnt), int'(e.fc));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
